z80_pin_mux_sequencer: RTL and testbench
========================================

// Module: z80_pin_mux_sequencer
// PURPOSE
//  Time-multiplexes the Z80 core bus (16b address, 8b data, 8 control strobes) onto the
//  8 dedicated outputs and 8 bidir pins of the tt_um_rejunity_z80 top level.
//  Runs a fixed 4-phase frame: ADDR_LO, ADDR_HI, CTRL, DATA.
//  Issues exactly one core clock-enable per frame, so the core advances one T-state per frame.
//  Sits between the core and the TT pin ports.
// PARAMETERS
//  STRETCH    0      extra cycles DATA phase is held (DATA lasts 1+STRETCH clks), for slow ext memory
//  DIN_RESET  8'h00  reset value of the data-in holding register
// PORTS
//  clk         in   1   system clock; all state on rising edge
//  rst         in   1   asynchronous, active-high reset
//  ena         in   1   design selected; 0 freezes the sequencer
//  cpu_addr    in   16  core address bus (live)
//  cpu_dout    in   8   core write data (live)
//  cpu_ctrl_n  in   8   core strobes, active low: [0]m1 [1]mreq [2]iorq [3]rd [4]wr [5]rfsh [6]halt [7]busak
//  cpu_din     out  8   read data to core
//  cpu_ce      out  1   core clock enable, 1-cycle pulse per frame
//  uo_out      out  8   dedicated output pins
//  uio_in      in   8   bidir pins, input path
//  uio_out     out  8   bidir pins, output path
//  uio_oe      out  8   bidir output enables (1=drive)
//  phase       out  2   current phase 0..3 (wrapper/debug)
// BEHAVIOUR
//  - Reset (async, any time):
//    - phase=0, stretch counter=0
//    - snapshot regs: addr=0, dout=0, ctrl=8'hFF
//    - din_q=DIN_RESET; cpu_ce=0, uio_oe=0, uio_out=0
//    - The first cycle after reset release is phase 0.
//  - Phase counter 2b:
//    - advances 0->1->2->3 one clk each when ena=1
//    - phase 3 held until stretch counter (0..STRETCH) hits STRETCH, then wraps to 0 and counter clears
//  - last3 = (phase==3) && (stretch cnt==STRETCH) && ena.
//  - cpu_ce = last3 (combinational, registered inputs only); the core updates on that edge.
//  - Phase 0 (ADDR_LO):
//    - uo_out = cpu_addr[7:0] live
//    - on the edge leaving phase 0, snapshot addr/dout/ctrl_n from core
//  - Phase 1 (ADDR_HI): uo_out = snap_addr[15:8].
//  - Phase 2 (CTRL): uo_out = snap_ctrl_n (bit map as cpu_ctrl_n; idle = 8'hFF).
//  - Phase 3 (DATA): uo_out = snap_addr[7:0] (repeat; lets ext latch addr+data together).
//  - Write, snap_ctrl_n[4]==0:
//    - uio_oe=8'hFF and uio_out=snap_dout in phases 1..3
//    - phase 0 always uio_oe=0, uio_out=0 (turnaround)
//  - Read/other: uio_oe=0, uio_out=0.
//  - cpu_din = last3 ? uio_in : din_q.
//    - din_q <= uio_in on the last3 edge when snap_ctrl_n[4]==1 (not a write); else holds.
//  - ena=0: phase, stretch cnt, snapshots, din_q hold; cpu_ce=0; uio_oe=0; uo_out keeps phase mapping.
//  - Reset mid-frame: frame aborted, no cpu_ce issued, bidir released immediately (async).
//  - Frame length = 4+STRETCH clks; cpu_ce period identical; no back-to-back cpu_ce possible.
// TESTING
//  1. rst=1, then release with ena=1 -> uo_out=0, uio_oe=0, cpu_ce=0, phase=0, cpu_din=DIN_RESET.
//  2. Read: addr=16'h1234, ctrl_n=8'hF4 (m1,mreq,rd low), uio_in=8'hA5 in phase 3
//     -> uo_out 34,12,F4,34 over 4 clks
//     -> cpu_ce=1 only in 4th clk, cpu_din=A5 then held, uio_oe=0 throughout.
//  3. Write: addr=16'hBEEF, dout=8'h5A, ctrl_n=8'hED (mreq,wr low)
//     -> uio_oe 00,FF,FF,FF; uio_out=5A in phases 1..3; din_q unchanged.
//  4. STRETCH=2 -> phase 3 lasts 3 clks, cpu_ce once per 6 clks, din sampled on the 3rd DATA clk only.
//  5. ena dropped in phase 2 for 5 clks -> phase stays 2, no cpu_ce, uio_oe=0; resumes to phase 3 on ena=1.
//  6. rst pulsed in phase 3 of a write -> uio_oe=0 same cycle (async), no cpu_ce, restart at phase 0 with ctrl snap FF.

Source files
------------

// File: rtl/z80_pin_mux_sequencer.sv
// Z80 pin mux sequencer: squeezes the core bus onto the TT pins with a
// 4-phase frame (ADDR_LO, ADDR_HI, CTRL, DATA) and one core clock-enable per frame.
module z80_pin_mux_sequencer #(
  parameter int          STRETCH   = 0,
  parameter logic [7:0]  DIN_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  cpu_ctrl_n,
  output logic [7:0]  cpu_din,
  output logic        cpu_ce,
  output logic [7:0]  uo_out,
  input  logic [7:0]  uio_in,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  output logic [1:0]  phase
);

  localparam int CW = (STRETCH > 0) ? $clog2(STRETCH + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STRETCH);

  typedef enum logic [1:0] {
    PH_ADDR_LO = 2'd0,
    PH_ADDR_HI = 2'd1,
    PH_CTRL    = 2'd2,
    PH_DATA    = 2'd3
  } phase_e;

  phase_e         ph_q, ph_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    snap_addr;
  logic [7:0]     snap_dout;
  logic [7:0]     snap_ctrl;
  logic [7:0]     din_q;
  logic           last3;
  logic           drive;

  assign last3 = (ph_q == PH_DATA) && (cnt_q == CMAX) && ena;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q  <= PH_ADDR_LO;
      cnt_q <= '0;
    end else begin
      ph_q  <= ph_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    ph_d  = ph_q;
    cnt_d = cnt_q;
    if (ena) begin
      unique case (ph_q)
        PH_ADDR_LO: ph_d = PH_ADDR_HI;
        PH_ADDR_HI: ph_d = PH_CTRL;
        PH_CTRL:    ph_d = PH_DATA;
        PH_DATA: begin
          if (cnt_q == CMAX) begin
            ph_d  = PH_ADDR_LO;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ph_d = PH_ADDR_LO;
      endcase
    end
  end

  // Core bus is captured once per frame so later phases see a stable cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_addr <= '0;
      snap_dout <= '0;
      snap_ctrl <= 8'hFF;
      din_q     <= DIN_RESET;
    end else begin
      if (ena && ph_q == PH_ADDR_LO) begin
        snap_addr <= cpu_addr;
        snap_dout <= cpu_dout;
        snap_ctrl <= cpu_ctrl_n;
      end
      if (last3 && snap_ctrl[4])
        din_q <= uio_in;
    end
  end

  always_comb begin
    uo_out = cpu_addr[7:0];
    unique case (ph_q)
      PH_ADDR_LO: uo_out = cpu_addr[7:0];
      PH_ADDR_HI: uo_out = snap_addr[15:8];
      PH_CTRL:    uo_out = snap_ctrl;
      PH_DATA:    uo_out = snap_addr[7:0];
      default:    uo_out = cpu_addr[7:0];
    endcase
  end

  // Phase 0 is a bus turnaround slot, never driven
  assign drive   = !snap_ctrl[4] && (ph_q != PH_ADDR_LO);
  assign uio_out = drive ? snap_dout : 8'h00;
  assign uio_oe  = (drive && ena) ? 8'hFF : 8'h00;
  assign cpu_ce  = last3;
  assign cpu_din = last3 ? uio_in : din_q;
  assign phase   = ph_q;

endmodule

// File: tb/tb_z80_pin_mux_sequencer.sv
// Scoreboard bench for z80_pin_mux_sequencer: STRETCH=0 main instance and
// a STRETCH=2 instance sharing the same stimulus.
module tb_z80_pin_mux_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_ctrl_n;
  logic [7:0]  uio_in;

  logic [7:0]  cpu_din, uo_out, uio_out, uio_oe;
  logic        cpu_ce;
  logic [1:0]  phase;

  logic [7:0]  cpu_din2, uo_out2, uio_out2, uio_oe2;
  logic        cpu_ce2;
  logic [1:0]  phase2;

  int errors = 0;
  int checks = 0;

  // {phase, uo_out, uio_oe, uio_out, cpu_ce, cpu_din}
  logic [34:0] exp_q[$];

  always #5 clk = ~clk;

  z80_pin_mux_sequencer #(.STRETCH(0), .DIN_RESET(8'h00)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_ctrl_n(cpu_ctrl_n),
    .cpu_din(cpu_din), .cpu_ce(cpu_ce), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe), .phase(phase)
  );

  z80_pin_mux_sequencer #(.STRETCH(2), .DIN_RESET(8'h00)) dut2 (
    .clk(clk), .rst(rst), .ena(ena),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_ctrl_n(cpu_ctrl_n),
    .cpu_din(cpu_din2), .cpu_ce(cpu_ce2), .uo_out(uo_out2),
    .uio_in(uio_in), .uio_out(uio_out2), .uio_oe(uio_oe2), .phase(phase2)
  );

  task automatic test_reset();
    logic [34:0] e, a;
    rst = 1'b1;
    ena = 1'b1;
    @(negedge clk);
    exp_q.push_back({2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00});
    exp_q.push_back({2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00});
    for (int k = 0; k < 2; k++) begin
      if (k == 1) rst = 1'b0;
      #1;
      e = exp_q.pop_front();
      a = {phase, uo_out, uio_oe, uio_out, cpu_ce, cpu_din};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset k=%0d act=%h exp=%h", k, a, e);
      end
      if (k == 0) @(negedge clk);
    end
  endtask

  task automatic test_read();
    logic [34:0] e, a;
    exp_q.push_back({2'd0, 8'h34, 8'h00, 8'h00, 1'b0, 8'h00});
    exp_q.push_back({2'd1, 8'h12, 8'h00, 8'h00, 1'b0, 8'h00});
    exp_q.push_back({2'd2, 8'hF4, 8'h00, 8'h00, 1'b0, 8'h00});
    exp_q.push_back({2'd3, 8'h34, 8'h00, 8'h00, 1'b1, 8'hA5});
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        cpu_addr = 16'h1234; cpu_ctrl_n = 8'hF4; cpu_dout = 8'h00; uio_in = 8'h00;
      end
      if (k == 1) begin cpu_addr = 16'h0000; cpu_ctrl_n = 8'hFF; end
      if (k == 3) uio_in = 8'hA5;
      #1;
      e = exp_q.pop_front();
      a = {phase, uo_out, uio_oe, uio_out, cpu_ce, cpu_din};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL read k=%0d act=%h exp=%h", k, a, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write();
    logic [34:0] e, a;
    exp_q.push_back({2'd0, 8'hEF, 8'h00, 8'h00, 1'b0, 8'hA5});
    exp_q.push_back({2'd1, 8'hBE, 8'hFF, 8'h5A, 1'b0, 8'hA5});
    exp_q.push_back({2'd2, 8'hED, 8'hFF, 8'h5A, 1'b0, 8'hA5});
    exp_q.push_back({2'd3, 8'hEF, 8'hFF, 8'h5A, 1'b1, 8'h33});
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        cpu_addr = 16'hBEEF; cpu_dout = 8'h5A; cpu_ctrl_n = 8'hED; uio_in = 8'h00;
      end
      if (k == 1) begin cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_ctrl_n = 8'hFF; end
      if (k == 3) uio_in = 8'h33;
      #1;
      e = exp_q.pop_front();
      a = {phase, uo_out, uio_oe, uio_out, cpu_ce, cpu_din};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL write k=%0d act=%h exp=%h", k, a, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ena_hold();
    logic [34:0] e, a;
    exp_q.push_back({2'd0, 8'h21, 8'h00, 8'h00, 1'b0, 8'hA5});
    exp_q.push_back({2'd1, 8'h43, 8'hFF, 8'hC3, 1'b0, 8'hA5});
    for (int k = 2; k < 7; k++)
      exp_q.push_back({2'd2, 8'hED, 8'h00, 8'hC3, 1'b0, 8'hA5});
    exp_q.push_back({2'd2, 8'hED, 8'hFF, 8'hC3, 1'b0, 8'hA5});
    exp_q.push_back({2'd3, 8'h21, 8'hFF, 8'hC3, 1'b1, 8'h77});
    for (int k = 0; k < 9; k++) begin
      if (k == 0) begin
        cpu_addr = 16'h4321; cpu_dout = 8'hC3; cpu_ctrl_n = 8'hED; uio_in = 8'h00;
      end
      if (k == 1) begin cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_ctrl_n = 8'hFF; end
      ena = (k >= 2 && k < 7) ? 1'b0 : 1'b1;
      if (k == 8) uio_in = 8'h77;
      #1;
      e = exp_q.pop_front();
      a = {phase, uo_out, uio_oe, uio_out, cpu_ce, cpu_din};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ena_hold k=%0d act=%h exp=%h", k, a, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [34:0] e, a;
    exp_q.push_back({2'd0, 8'h78, 8'h00, 8'h00, 1'b0, 8'hA5});
    exp_q.push_back({2'd1, 8'h56, 8'hFF, 8'h99, 1'b0, 8'hA5});
    exp_q.push_back({2'd2, 8'hED, 8'hFF, 8'h99, 1'b0, 8'hA5});
    exp_q.push_back({2'd0, 8'hAB, 8'h00, 8'h00, 1'b0, 8'h00});
    exp_q.push_back({2'd0, 8'hAB, 8'h00, 8'h00, 1'b0, 8'h00});
    exp_q.push_back({2'd1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00});
    exp_q.push_back({2'd2, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00});
    exp_q.push_back({2'd3, 8'hAB, 8'h00, 8'h00, 1'b1, 8'h00});
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        cpu_addr = 16'h5678; cpu_dout = 8'h99; cpu_ctrl_n = 8'hED; uio_in = 8'h00;
      end
      if (k == 1) begin cpu_addr = 16'h00AB; cpu_dout = 8'h00; cpu_ctrl_n = 8'hFF; end
      if (k == 3) rst = 1'b1;
      if (k == 4) rst = 1'b0;
      #1;
      e = exp_q.pop_front();
      a = {phase, uo_out, uio_oe, uio_out, cpu_ce, cpu_din};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset_mid k=%0d act=%h exp=%h", k, a, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stretch();
    logic [34:0] e, a;
    logic [1:0]  ph;
    logic [7:0]  din;
    rst = 1'b1;
    cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_ctrl_n = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    din = 8'h00;
    for (int k = 0; k < 12; k++) begin
      ph = ((k % 6) < 3) ? 2'(k % 6) : 2'd3;
      if (k % 6 == 5) din = 8'h10 + 8'(k);
      exp_q.push_back({ph, (ph == 2'd2) ? 8'hFF : 8'h00, 8'h00, 8'h00,
                       (k % 6 == 5), din});
    end
    for (int k = 0; k < 12; k++) begin
      uio_in = 8'h10 + 8'(k);
      #1;
      e = exp_q.pop_front();
      a = {phase2, uo_out2, uio_oe2, uio_out2, cpu_ce2, cpu_din2};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL stretch k=%0d act=%h exp=%h", k, a, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    cpu_addr = 16'h0000;
    cpu_dout = 8'h00;
    cpu_ctrl_n = 8'hFF;
    uio_in = 8'h00;
    test_reset();
    test_read();
    test_write();
    test_ena_hold();
    test_reset_mid();
    test_stretch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
